// File: rtl/sdx_kernel_wizard_0_example_vop_pkg.sv
// Shared types and helpers for the vadd per-lane operation pipeline.
// Holds the operation and FSM encodings plus the byte-to-beat conversion.
package sdx_kernel_wizard_0_example_vop_pkg;

    typedef enum logic [1:0] {
        VOP_ADD    = 2'd0,
        VOP_SUB    = 2'd1,
        VOP_SATADD = 2'd2,
        VOP_MAX    = 2'd3
    } vop_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } vop_state_t;

    // Round-up division by a power-of-two beat size; 65 bits keeps an all-ones
    // byte count of up to 64 bits from wrapping.
    function automatic logic [64:0] beats_from_bytes(input logic [64:0] bytes,
                                                     input int unsigned shift);
        logic [64:0] round_up;
        round_up = (65'd1 << shift) - 65'd1;
        return (bytes + round_up) >> shift;
    endfunction

endpackage

// File: rtl/sdx_kernel_wizard_0_example_vop_lane.sv
// One arithmetic lane: combinational add / sub / saturating add / max of a
// lane value against the per-transfer constant.
module sdx_kernel_wizard_0_example_vop_lane
    import sdx_kernel_wizard_0_example_vop_pkg::*;
#(
    parameter int unsigned C_LANE_WIDTH = 32
) (
    input  logic [C_LANE_WIDTH-1:0] a,
    input  logic [C_LANE_WIDTH-1:0] k,
    input  vop_mode_t               mode,
    output logic [C_LANE_WIDTH-1:0] y
);

    logic [C_LANE_WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, k};
        y   = '0;
        case (mode)
            VOP_ADD:    y = sum[C_LANE_WIDTH-1:0];
            VOP_SUB:    y = a - k;
            VOP_SATADD: y = sum[C_LANE_WIDTH] ? '1 : sum[C_LANE_WIDTH-1:0];
            VOP_MAX:    y = (a > k) ? a : k;
            default:    y = '0;
        endcase
    end

endmodule

// File: rtl/sdx_kernel_wizard_0_example_vop_pipe.sv
// Pipelined per-lane operation stage between the AXI read and write streams;
// counts beats, generates m_axis_tlast and pulses ctrl_done on completion.
module sdx_kernel_wizard_0_example_vop_pipe
    import sdx_kernel_wizard_0_example_vop_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
    parameter int unsigned C_LANE_WIDTH       = 32,
    parameter int unsigned C_PIPE_STAGES      = 2,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          ctrl_start,
    input  logic [1:0]                    ctrl_mode,
    input  logic [C_LANE_WIDTH-1:0]       ctrl_constant,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
    output logic                          ctrl_done,
    output logic                          ctrl_busy,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic                          stat_tlast_err
);

    localparam int unsigned LANES      = C_AXIS_TDATA_WIDTH / C_LANE_WIDTH;
    localparam int unsigned BEAT_SHIFT = $clog2(C_AXIS_TDATA_WIDTH / 8);
    localparam int unsigned CW         = C_XFER_SIZE_WIDTH + 1;

    vop_state_t                    state_q, state_d;
    vop_mode_t                     mode_q, mode_d;
    logic [C_LANE_WIDTH-1:0]       k_q, k_d;
    logic [CW-1:0]                 n_q, n_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic                          err_q, err_d;
    logic [C_PIPE_STAGES-1:0]      vld_q, vld_d;
    logic [C_AXIS_TDATA_WIDTH-1:0] data_q [C_PIPE_STAGES];
    logic [C_AXIS_TDATA_WIDTH-1:0] data_d [C_PIPE_STAGES];

    logic [C_AXIS_TDATA_WIDTH-1:0] op_res;
    logic [CW-1:0]                 n_start;
    logic                          stall, s_acc, m_hs, in_last;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sdx_kernel_wizard_0_example_vop_lane #(
            .C_LANE_WIDTH(C_LANE_WIDTH)
        ) u_lane (
            .a    (s_axis_tdata[i*C_LANE_WIDTH +: C_LANE_WIDTH]),
            .k    (k_q),
            .mode (mode_q),
            .y    (op_res[i*C_LANE_WIDTH +: C_LANE_WIDTH])
        );
    end

    always_comb begin
        n_start        = CW'(beats_from_bytes(65'({1'b0, ctrl_xfer_size_in_bytes}), BEAT_SHIFT));
        stall          = vld_q[C_PIPE_STAGES-1] && !m_axis_tready;
        in_last        = (in_cnt_q == n_q - CW'(1));
        s_axis_tready  = (state_q == RUN) && (in_cnt_q < n_q) && !stall;
        s_acc          = s_axis_tvalid && s_axis_tready;
        m_axis_tvalid  = vld_q[C_PIPE_STAGES-1];
        m_axis_tdata   = data_q[C_PIPE_STAGES-1];
        m_axis_tlast   = vld_q[C_PIPE_STAGES-1] && (out_cnt_q == n_q - CW'(1));
        m_hs           = vld_q[C_PIPE_STAGES-1] && m_axis_tready;
        ctrl_done      = (state_q == DONE);
        ctrl_busy      = (state_q != IDLE);
        stat_tlast_err = err_q;
    end

    // Control FSM and beat counters; a start in IDLE overrides counter updates.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        k_d       = k_q;
        n_d       = n_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        err_d     = err_q;

        if (s_acc) begin
            in_cnt_d = in_cnt_q + CW'(1);
            if (s_axis_tlast != in_last) err_d = 1'b1;
        end
        if (m_hs) out_cnt_d = out_cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (ctrl_start) begin
                    mode_d    = vop_mode_t'(ctrl_mode);
                    k_d       = ctrl_constant;
                    n_d       = n_start;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    err_d     = 1'b0;
                    state_d   = (n_start == '0) ? DONE : RUN;
                end
            end
            RUN:     if (s_acc && in_last) state_d = DRAIN;
            DRAIN:   if (m_hs && m_axis_tlast) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All stages advance together unless the output is stalled; bubbles stay put.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (!stall) begin
            vld_d[0]  = s_acc;
            data_d[0] = op_res;
            for (int unsigned i = 1; i < C_PIPE_STAGES; i++) begin
                vld_d[i]  = vld_q[i-1];
                data_d[i] = data_q[i-1];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            mode_q    <= VOP_ADD;
            k_q       <= '0;
            n_q       <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
            vld_q     <= '0;
            for (int unsigned i = 0; i < C_PIPE_STAGES; i++) data_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            k_q       <= k_d;
            n_q       <= n_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
            vld_q     <= vld_d;
            data_q    <= data_d;
        end
    end

endmodule

// File: tb/tb_sdx_kernel_wizard_0_example_vop_pipe.sv
// Directed bench for the vop pipe: 512-bit stream, 8-bit lanes, 2 stages.
module tb_sdx_kernel_wizard_0_example_vop_pipe;

    localparam int unsigned DW    = 512;
    localparam int unsigned LW    = 8;
    localparam int unsigned LANES = DW / LW;

    logic          aclk = 1'b0;
    logic          areset;
    logic          ctrl_start;
    logic [1:0]    ctrl_mode;
    logic [LW-1:0] ctrl_constant;
    logic [31:0]   ctrl_xfer_size_in_bytes;
    logic          ctrl_done, ctrl_busy;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [DW-1:0] s_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          stat_tlast_err;

    always #5 aclk = ~aclk;

    sdx_kernel_wizard_0_example_vop_pipe #(
        .C_AXIS_TDATA_WIDTH (DW),
        .C_LANE_WIDTH       (LW),
        .C_PIPE_STAGES      (2),
        .C_XFER_SIZE_WIDTH  (32)
    ) dut (
        .aclk                    (aclk),
        .areset                  (areset),
        .ctrl_start              (ctrl_start),
        .ctrl_mode               (ctrl_mode),
        .ctrl_constant           (ctrl_constant),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .ctrl_done               (ctrl_done),
        .ctrl_busy               (ctrl_busy),
        .s_axis_tvalid           (s_axis_tvalid),
        .s_axis_tready           (s_axis_tready),
        .s_axis_tdata            (s_axis_tdata),
        .s_axis_tlast            (s_axis_tlast),
        .m_axis_tvalid           (m_axis_tvalid),
        .m_axis_tready           (m_axis_tready),
        .m_axis_tdata            (m_axis_tdata),
        .m_axis_tlast            (m_axis_tlast),
        .stat_tlast_err          (stat_tlast_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] src [8];
    logic          src_last [8];
    int            n_src;
    logic [DW-1:0] got [8];
    logic [7:0]    got_lastmask;
    int            n_got, n_acc, n_tlast, done_cnt, done_cyc, first_acc, first_out, last_hs;
    bit            stall_viol;
    logic [DW-1:0] e;

    // Cycle 0 carries the start pulse; monitor samples at negedge, drive at posedge+1.
    task automatic run_xfer(input logic [1:0] mode, input logic [LW-1:0] k,
                            input logic [31:0] bytes, input bit toggle,
                            input int start_again, input int ncyc);
        int si;
        si = 0;
        n_got = 0; n_acc = 0; n_tlast = 0; done_cnt = 0; done_cyc = -1;
        first_acc = -1; first_out = -1; last_hs = -1; stall_viol = 1'b0;
        got_lastmask = '0;
        for (int i = 0; i < 8; i++) got[i] = '0;
        @(posedge aclk); #1;
        ctrl_start = 1'b1; ctrl_mode = mode; ctrl_constant = k; ctrl_xfer_size_in_bytes = bytes;
        s_axis_tvalid = (n_src > 0); s_axis_tdata = src[0]; s_axis_tlast = src_last[0];
        m_axis_tready = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge aclk);
            if (s_axis_tvalid && s_axis_tready) begin
                if (n_acc == 0) first_acc = c;
                n_acc++; si++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (n_got < 8) begin
                    got[n_got] = m_axis_tdata;
                    got_lastmask[n_got] = m_axis_tlast;
                end
                if (n_got == 0) first_out = c;
                if (m_axis_tlast) n_tlast++;
                n_got++; last_hs = c;
            end
            if (ctrl_done) begin done_cnt++; done_cyc = c; end
            if (m_axis_tvalid && !m_axis_tready && s_axis_tready) stall_viol = 1'b1;
            @(posedge aclk); #1;
            ctrl_start = (c + 1 == start_again);
            if (ctrl_start) begin
                ctrl_mode = 2'd1; ctrl_constant = 8'hAA; ctrl_xfer_size_in_bytes = 32'd64;
            end
            s_axis_tvalid = (si < n_src);
            if (si < n_src) begin s_axis_tdata = src[si]; s_axis_tlast = src_last[si]; end
            m_axis_tready = toggle ? ~m_axis_tready : 1'b1;
        end
        ctrl_start = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    endtask

    task automatic clear_src();
        n_src = 0;
        for (int b = 0; b < 8; b++) begin src[b] = '0; src_last[b] = 1'b0; end
    endtask

    initial begin
        areset = 1'b1; ctrl_start = 1'b0; ctrl_mode = 2'd0; ctrl_constant = '0;
        ctrl_xfer_size_in_bytes = '0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
        clear_src();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tdata", m_axis_tdata, '0);
        check("rst_ctrl", DW'({m_axis_tvalid, m_axis_tlast, s_axis_tready, ctrl_done, ctrl_busy, stat_tlast_err}), '0);
        @(posedge aclk); #1; areset = 1'b0;

        // Add 5, 4 beats, lane i of beat b = i+b; a changed start in RUN must be ignored.
        clear_src(); n_src = 4;
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < LANES; i++) src[b][i*LW +: LW] = LW'(i + b);
        src_last[3] = 1'b1;
        run_xfer(2'd0, 8'd5, 32'd256, 1'b0, 3, 14);
        check("add_acc", DW'(n_acc), DW'(4));
        check("add_beats", DW'(n_got), DW'(4));
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < LANES; i++) e[i*LW +: LW] = LW'(i + b + 5);
            check($sformatf("add_data%0d", b), got[b], e);
        end
        check("add_tlast", DW'(got_lastmask), DW'(8'b0000_1000));
        check("add_ntlast", DW'(n_tlast), DW'(1));
        check("add_latency", DW'(first_out - first_acc), DW'(2));
        check("add_done_lat", DW'(done_cyc - last_hs), DW'(1));
        check("add_done_cnt", DW'(done_cnt), DW'(1));
        check("add_err", DW'(stat_tlast_err), '0);

        // Saturating add 0x10: F8 -> FF, 20 -> 30, zeros -> 10.
        clear_src(); n_src = 1; src_last[0] = 1'b1;
        src[0][7:0] = 8'hF8; src[0][15:8] = 8'h20;
        run_xfer(2'd2, 8'h10, 32'd64, 1'b0, 0, 8);
        for (int i = 0; i < LANES; i++) e[i*LW +: LW] = 8'h10;
        e[7:0] = 8'hFF; e[15:8] = 8'h30;
        check("sat_data", got[0], e);
        check("sat_beats", DW'(n_got), DW'(1));
        check("sat_tlast", DW'(got_lastmask), DW'(8'b1));

        // Subtract 1 from zero lanes wraps to FF.
        clear_src(); n_src = 1; src_last[0] = 1'b1;
        run_xfer(2'd1, 8'h01, 32'd64, 1'b0, 0, 8);
        check("sub_wrap", got[0], '1);

        // Max 0x40, 100 bytes -> 2 beats, ready toggling, a third beat offered but never taken.
        clear_src(); n_src = 3; src_last[1] = 1'b1;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < LANES; i++) src[b][i*LW +: LW] = LW'(i * 4 + b);
        run_xfer(2'd3, 8'h40, 32'd100, 1'b1, 0, 14);
        check("max_acc", DW'(n_acc), DW'(2));
        check("max_beats", DW'(n_got), DW'(2));
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < LANES; i++) e[i*LW +: LW] = (i * 4 + b > 64) ? LW'(i * 4 + b) : 8'h40;
            check($sformatf("max_data%0d", b), got[b], e);
        end
        check("max_tlast", DW'(got_lastmask), DW'(8'b10));
        check("max_stall_rdy", DW'(stall_viol), '0);
        check("max_done_cnt", DW'(done_cnt), DW'(1));

        // Zero-length transfer: a done pulse soon after start and no stream traffic.
        clear_src();
        run_xfer(2'd0, 8'd0, 32'd0, 1'b0, 0, 6);
        check("zero_done_cnt", DW'(done_cnt), DW'(1));
        check("zero_done_soon", DW'(done_cyc >= 1 && done_cyc <= 2), DW'(1));
        check("zero_traffic", DW'(n_acc + n_got), '0);

        // Upstream tlast on beat 1 of 4 with stalls: flag set, output framing intact.
        clear_src(); n_src = 4; src_last[1] = 1'b1;
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < LANES; i++) src[b][i*LW +: LW] = LW'(i ^ b);
        run_xfer(2'd0, 8'd0, 32'd256, 1'b1, 0, 20);
        check("err_flag", DW'(stat_tlast_err), DW'(1));
        check("err_beats", DW'(n_got), DW'(4));
        check("err_tlast", DW'(got_lastmask), DW'(8'b1000));
        check("err_stall_rdy", DW'(stall_viol), '0);
        check("err_data3", got[3], src[3]);
        clear_src();
        run_xfer(2'd0, 8'd0, 32'd0, 1'b0, 0, 4);
        check("err_cleared", DW'(stat_tlast_err), '0);

        // Reset in DRAIN with one beat held in the pipe.
        @(posedge aclk); #1;
        ctrl_start = 1'b1; ctrl_mode = 2'd0; ctrl_constant = 8'd1; ctrl_xfer_size_in_bytes = 32'd64;
        s_axis_tvalid = 1'b1; s_axis_tdata = '0; s_axis_tlast = 1'b1; m_axis_tready = 1'b0;
        @(posedge aclk); #1; ctrl_start = 1'b0;
        @(posedge aclk); #1; s_axis_tvalid = 1'b0;
        @(negedge aclk);
        check("rst_mid_drain", DW'({ctrl_busy, s_axis_tready, m_axis_tvalid}), DW'(3'b100));
        areset = 1'b1;
        @(posedge aclk); #1; areset = 1'b0; m_axis_tready = 1'b1;
        @(negedge aclk);
        check("rst_mid_out", DW'({m_axis_tvalid, ctrl_busy, ctrl_done}), '0);
        @(negedge aclk);
        check("rst_mid_nodone", DW'({m_axis_tvalid, ctrl_done}), '0);

        clear_src(); n_src = 2; src_last[1] = 1'b1;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < LANES; i++) src[b][i*LW +: LW] = LW'(2 * i + b);
        run_xfer(2'd0, 8'd3, 32'd128, 1'b0, 0, 10);
        check("post_rst_beats", DW'(n_got), DW'(2));
        for (int i = 0; i < LANES; i++) e[i*LW +: LW] = LW'(2 * i + 1 + 3);
        check("post_rst_data1", got[1], e);
        check("post_rst_done", DW'(done_cnt), DW'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
